// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch/timer controller: FSM states, count direction, lap-count width.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Count must represent 0..depth inclusive.
  function automatic int lap_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stopwatch_lap_control_if.sv
// Button/tick inputs, unit-counter feedback and lap readout between the button block and the time-digit chain.
interface stopwatch_lap_control_if
  import stopwatch_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int LAP_DEPTH = 4,
  parameter int TIME_W    = 32
);
  localparam int CNT_W = lap_cnt_w(LAP_DEPTH);

  logic                 i_set;
  logic                 i_up;
  logic                 i_right;
  logic                 i_down;
  logic                 i_left;
  logic                 i_mode_timer;
  logic                 i_tick;
  logic [NUM_UNITS-1:0] i_carry;
  logic                 i_zero;
  logic [TIME_W-1:0]    i_time;

  logic [NUM_UNITS-1:0] o_up;
  logic [NUM_UNITS-1:0] o_down;
  logic                 o_run;
  logic                 o_expired;
  logic [TIME_W-1:0]    o_lap_data;
  logic                 o_lap_valid;
  logic [CNT_W-1:0]     o_lap_count;
  logic                 o_lap_ovf;

  modport master (
    output i_set, i_up, i_right, i_down, i_left, i_mode_timer, i_tick, i_carry, i_zero, i_time,
    input  o_up, o_down, o_run, o_expired, o_lap_data, o_lap_valid, o_lap_count, o_lap_ovf
  );

  modport slave (
    input  i_set, i_up, i_right, i_down, i_left, i_mode_timer, i_tick, i_carry, i_zero, i_time,
    output o_up, o_down, o_run, o_expired, o_lap_data, o_lap_valid, o_lap_count, o_lap_ovf
  );

endinterface

// File: rtl/lap_fifo.sv
// Lap-time FIFO with registered first-word-fall-through head; push/pop take effect on the next edge.
// Never stalls: a push into a full buffer without a pop is dropped and latches a sticky overflow.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_din,
  output logic [W-1:0]               o_data,
  output logic [lap_cnt_w(DEPTH)-1:0] o_count,
  output logic                       o_ovf
);
  localparam int CNT_W = lap_cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = i_pop && !empty;
  assign do_push = i_push && (!full || do_pop);
  assign rd_nxt  = ptr_inc(rd_ptr);

  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_data <= '0;
      o_ovf  <= 1'b0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_data <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (i_push && full && !do_pop) o_ovf <= 1'b1;
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
      // Head refresh: a push into an emptying buffer becomes the new head directly.
      if (do_push && (empty || (do_pop && count == CNT_W'(1)))) o_data <= i_din;
      else if (do_pop && count > CNT_W'(1))                    o_data <= mem[rd_nxt];
    end
  end

  assign o_count = count;

endmodule

// File: rtl/stopwatch_lap_control.sv
// Stopwatch/timer run-pause-expire FSM driving per-unit count strobes (combinational, same cycle) and a lap buffer.
// Registered state outputs one cycle after the button; no backpressure, every pulse is acted on or ignored.
module stopwatch_lap_control
  import stopwatch_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int LAP_DEPTH = 4,
  parameter int TIME_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  stopwatch_lap_control_if.slave bus
);
  state_t               state;
  logic                 r_mode;
  logic                 r_run;
  logic                 r_expired;
  logic                 toggle;
  logic                 any_btn;
  logic                 running;
  logic [NUM_UNITS-1:0] step_src;
  logic [NUM_UNITS-1:0] up_s;
  logic [NUM_UNITS-1:0] down_s;
  logic                 lap_push;
  logic                 lap_pop;
  logic                 unused_carry;

  assign toggle  = bus.i_up | bus.i_right;
  assign any_btn = bus.i_up | bus.i_right | bus.i_down | bus.i_left;
  assign running = (state == RUN);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      r_mode    <= MODE_UP;
      r_run     <= 1'b0;
      r_expired <= 1'b0;
    end else if (bus.i_set) begin
      state     <= IDLE;
      r_run     <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A timer cannot start from an all-zero preset.
          if (toggle && !(bus.i_mode_timer && bus.i_zero)) begin
            state  <= RUN;
            r_run  <= 1'b1;
            r_mode <= bus.i_mode_timer;
          end
        end
        RUN: begin
          if (toggle) begin
            state <= PAUSE;
            r_run <= 1'b0;
          end else if (r_mode == MODE_DOWN && bus.i_zero) begin
            state     <= EXPIRED;
            r_run     <= 1'b0;
            r_expired <= 1'b1;
          end
        end
        PAUSE: begin
          if (toggle) begin
            state <= RUN;
            r_run <= 1'b1;
          end
        end
        EXPIRED: begin
          if (any_btn) begin
            state     <= IDLE;
            r_expired <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          r_run     <= 1'b0;
          r_expired <= 1'b0;
        end
      endcase
    end
  end

  // Unit 0 steps on the ms tick, unit k on the carry/borrow out of unit k-1.
  always_comb begin
    step_src = '0;
    step_src[0] = bus.i_tick;
    for (int k = 1; k < NUM_UNITS; k++) step_src[k] = bus.i_carry[k-1];
  end

  assign unused_carry = bus.i_carry[NUM_UNITS-1];

  always_comb begin
    up_s   = '0;
    down_s = '0;
    if (running) begin
      if (r_mode == MODE_UP) up_s = step_src;
      else if (!bus.i_zero)  down_s = step_src;
    end
  end

  assign bus.o_up      = bus.i_set ? '1 : up_s;
  assign bus.o_down    = bus.i_set ? '1 : down_s;
  assign bus.o_run     = r_run;
  assign bus.o_expired = r_expired;

  // Capture looks at the pre-toggle state; a button that only dismisses EXPIRED must not pop.
  assign lap_push = bus.i_down && running && !bus.i_set;
  assign lap_pop  = bus.i_left && (state != EXPIRED) && !bus.i_set;

  lap_fifo #(
    .DEPTH (LAP_DEPTH),
    .W     (TIME_W)
  ) u_lap_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (lap_push),
    .i_pop   (lap_pop),
    .i_flush (bus.i_set),
    .i_din   (bus.i_time),
    .o_data  (bus.o_lap_data),
    .o_count (bus.o_lap_count),
    .o_ovf   (bus.o_lap_ovf)
  );

  assign bus.o_lap_valid = (bus.o_lap_count != '0);

endmodule

// File: tb/tb_stopwatch_lap_control.sv
// Directed bench for stopwatch_lap_control: inputs change on the falling edge, outputs sampled 1 ns later.
module tb_stopwatch_lap_control;
  localparam int NU = 4;
  localparam int LD = 4;
  localparam int TW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stopwatch_lap_control_if #(.NUM_UNITS(NU), .LAP_DEPTH(LD), .TIME_W(TW)) bus ();

  stopwatch_lap_control #(.NUM_UNITS(NU), .LAP_DEPTH(LD), .TIME_W(TW)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.i_set   = 1'b0;
    bus.i_up    = 1'b0;
    bus.i_right = 1'b0;
    bus.i_down  = 1'b0;
    bus.i_left  = 1'b0;
    bus.i_tick  = 1'b0;
    bus.i_carry = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    bus.i_mode_timer = 1'b0;
    bus.i_zero       = 1'b0;
    bus.i_time       = '0;
    #2;
    chk("rst_run",     32'(bus.o_run), 32'd0);
    chk("rst_expired", 32'(bus.o_expired), 32'd0);
    chk("rst_valid",   32'(bus.o_lap_valid), 32'd0);
    chk("rst_count",   32'(bus.o_lap_count), 32'd0);
    chk("rst_data",    32'(bus.o_lap_data), 32'd0);
    chk("rst_ovf",     32'(bus.o_lap_ovf), 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Stopwatch start and ticking
    @(negedge clk); clr(); bus.i_up = 1'b1; step();
    chk("sw_start_run", 32'(bus.o_run), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clr(); bus.i_tick = 1'b1; #1;
      chk("sw_tick_up",   32'(bus.o_up), 32'h1);
      chk("sw_tick_down", 32'(bus.o_down), 32'h0);
    end
    @(negedge clk); clr(); bus.i_tick = 1'b1; bus.i_carry = 4'b0011; #1;
    chk("sw_carry_up", 32'(bus.o_up), 32'h7);

    // Pause freezes strobes
    @(negedge clk); clr(); bus.i_right = 1'b1; step();
    chk("pause_run", 32'(bus.o_run), 32'd0);
    @(negedge clk); clr(); bus.i_tick = 1'b1; #1;
    chk("pause_tick_up", 32'(bus.o_up), 32'h0);

    @(negedge clk); clr(); bus.i_set = 1'b1; #1;
    chk("set_pause_up",   32'(bus.o_up), 32'hf);
    chk("set_pause_down", 32'(bus.o_down), 32'hf);
    step();

    // Timer mode: count down, capture a lap, expire, dismiss with i_left
    @(negedge clk); clr(); bus.i_mode_timer = 1'b1; bus.i_up = 1'b1; step();
    chk("tm_start_run", 32'(bus.o_run), 32'd1);
    @(negedge clk); clr(); bus.i_tick = 1'b1; bus.i_carry = 4'b0001; #1;
    chk("tm_tick_down", 32'(bus.o_down), 32'h3);
    chk("tm_tick_up",   32'(bus.o_up), 32'h0);
    @(negedge clk); clr(); bus.i_down = 1'b1; bus.i_time = 32'd7; step();
    chk("tm_lap_count", 32'(bus.o_lap_count), 32'd1);
    chk("tm_lap_data",  32'(bus.o_lap_data), 32'd7);
    @(negedge clk); clr(); bus.i_tick = 1'b1; bus.i_zero = 1'b1; #1;
    chk("tm_zero_down", 32'(bus.o_down), 32'h0);
    chk("tm_zero_up",   32'(bus.o_up), 32'h0);
    step();
    chk("tm_expired", 32'(bus.o_expired), 32'd1);
    chk("tm_exp_run", 32'(bus.o_run), 32'd0);
    @(negedge clk); clr(); bus.i_left = 1'b1; step();
    chk("exp_left_expired", 32'(bus.o_expired), 32'd0);
    chk("exp_left_count",   32'(bus.o_lap_count), 32'd1);

    // Timer start refused at zero
    @(negedge clk); clr(); bus.i_up = 1'b1; step();
    chk("tm_refuse_run", 32'(bus.o_run), 32'd0);
    chk("tm_refuse_exp", 32'(bus.o_expired), 32'd0);

    @(negedge clk); clr(); bus.i_set = 1'b1; step();
    chk("set_flush_count", 32'(bus.o_lap_count), 32'd0);
    chk("set_flush_data",  32'(bus.o_lap_data), 32'd0);
    @(negedge clk); clr(); bus.i_zero = 1'b0; bus.i_mode_timer = 1'b0;
    bus.i_down = 1'b1; bus.i_time = 32'd3; step();
    chk("idle_lap_ignored", 32'(bus.o_lap_count), 32'd0);

    // Overfill the lap buffer, then drain it
    @(negedge clk); clr(); bus.i_up = 1'b1; step();
    chk("lap_run", 32'(bus.o_run), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); clr(); bus.i_down = 1'b1; bus.i_time = 32'(i); step();
    end
    chk("ovf_count", 32'(bus.o_lap_count), 32'd4);
    chk("ovf_flag",  32'(bus.o_lap_ovf), 32'd1);
    chk("ovf_head",  32'(bus.o_lap_data), 32'd1);
    chk("ovf_valid", 32'(bus.o_lap_valid), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); clr(); bus.i_left = 1'b1; step();
      chk("pop_data", 32'(bus.o_lap_data), 32'(i));
    end
    @(negedge clk); clr(); bus.i_left = 1'b1; step();
    chk("pop_last_valid", 32'(bus.o_lap_valid), 32'd0);
    chk("pop_last_count", 32'(bus.o_lap_count), 32'd0);
    chk("pop_last_hold",  32'(bus.o_lap_data), 32'd4);
    @(negedge clk); clr(); bus.i_left = 1'b1; step();
    chk("pop_empty_count", 32'(bus.o_lap_count), 32'd0);

    // Clear overflow, refill, then push and pop together while full
    @(negedge clk); clr(); bus.i_set = 1'b1; step();
    chk("set_ovf_clear", 32'(bus.o_lap_ovf), 32'd0);
    @(negedge clk); clr(); bus.i_up = 1'b1; step();
    for (int i = 5; i <= 8; i++) begin
      @(negedge clk); clr(); bus.i_down = 1'b1; bus.i_time = 32'(i); step();
    end
    chk("refill_count", 32'(bus.o_lap_count), 32'd4);
    chk("refill_ovf",   32'(bus.o_lap_ovf), 32'd0);
    chk("refill_head",  32'(bus.o_lap_data), 32'd5);
    @(negedge clk); clr(); bus.i_down = 1'b1; bus.i_left = 1'b1; bus.i_time = 32'd9; step();
    chk("pushpop_count", 32'(bus.o_lap_count), 32'd4);
    chk("pushpop_head",  32'(bus.o_lap_data), 32'd6);
    chk("pushpop_ovf",   32'(bus.o_lap_ovf), 32'd0);
    @(negedge clk); clr(); bus.i_left = 1'b1; step();
    chk("pushpop_next", 32'(bus.o_lap_data), 32'd7);
    chk("pushpop_cnt3", 32'(bus.o_lap_count), 32'd3);
    @(negedge clk); clr(); bus.i_set = 1'b1; #1;
    chk("set_run_up",   32'(bus.o_up), 32'hf);
    chk("set_run_down", 32'(bus.o_down), 32'hf);
    step();
    chk("set_run_idle",  32'(bus.o_run), 32'd0);
    chk("set_run_count", 32'(bus.o_lap_count), 32'd0);
    chk("set_run_ovf",   32'(bus.o_lap_ovf), 32'd0);

    // Asynchronous reset in the middle of a clock phase
    @(negedge clk); clr(); bus.i_up = 1'b1; step();
    @(negedge clk); clr(); bus.i_down = 1'b1; bus.i_time = 32'h55; step();
    chk("arst_pre_count", 32'(bus.o_lap_count), 32'd1);
    @(negedge clk); clr();
    #2 rstn = 1'b0;
    #1;
    chk("arst_run",   32'(bus.o_run), 32'd0);
    chk("arst_count", 32'(bus.o_lap_count), 32'd0);
    chk("arst_valid", 32'(bus.o_lap_valid), 32'd0);
    chk("arst_data",  32'(bus.o_lap_data), 32'd0);
    @(negedge clk); rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
